// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment scan driver.
//   - Segment patterns, bit order {a,b,c,d,e,f,g,dp}, active-high.
//   - Nibble codes with special meaning (blank, dash).
//   - Slot enumeration for the 4-slot scan (two tubes lit per slot).
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_SLOTS = 4;

    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_DASH  = 4'hF;

    localparam logic [7:0] SEG_0     = 8'hFC;  // a b c d e f
    localparam logic [7:0] SEG_1     = 8'h60;  // b c
    localparam logic [7:0] SEG_2     = 8'hDA;  // a b d e g
    localparam logic [7:0] SEG_3     = 8'hF2;  // a b c d g
    localparam logic [7:0] SEG_4     = 8'h66;  // b c f g
    localparam logic [7:0] SEG_5     = 8'hB6;  // a c d f g
    localparam logic [7:0] SEG_6     = 8'hBE;  // a c d e f g
    localparam logic [7:0] SEG_7     = 8'hE0;  // a b c
    localparam logic [7:0] SEG_8     = 8'hFE;  // a b c d e f g
    localparam logic [7:0] SEG_9     = 8'hF6;  // a b c d f g
    localparam logic [7:0] SEG_A     = 8'hEE;  // a b c e f g
    localparam logic [7:0] SEG_B     = 8'h3E;  // c d e f g   (lower-case b)
    localparam logic [7:0] SEG_C     = 8'h9C;  // a d e f
    localparam logic [7:0] SEG_D     = 8'h7A;  // b c d e g   (lower-case d)
    localparam logic [7:0] SEG_DASH  = 8'h02;  // g only
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Power-on frame: every tube shows the blank code.
    localparam logic [31:0] FRAME_BLANK = {8{CODE_BLANK}};

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    localparam slot_e SLOT_LAST = slot_e'(NUM_SLOTS - 1);

    function automatic slot_e next_slot(input slot_e s);
        case (s)
            SLOT0:   return SLOT1;
            SLOT1:   return SLOT2;
            SLOT2:   return SLOT3;
            default: return SLOT0;
        endcase
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// ----------------------------------------------------------------------------
// seg_decoder
// Combinational nibble -> 7-segment pattern.
//   i_code  in  4  nibble code (0-9, A-D, E=blank, F=dash)
//   o_seg   out 8  segments {a,b,c,d,e,f,g,dp}, active-high, dp always 0
// ----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0:       o_seg = SEG_0;
            4'h1:       o_seg = SEG_1;
            4'h2:       o_seg = SEG_2;
            4'h3:       o_seg = SEG_3;
            4'h4:       o_seg = SEG_4;
            4'h5:       o_seg = SEG_5;
            4'h6:       o_seg = SEG_6;
            4'h7:       o_seg = SEG_7;
            4'h8:       o_seg = SEG_8;
            4'h9:       o_seg = SEG_9;
            4'hA:       o_seg = SEG_A;
            4'hB:       o_seg = SEG_B;
            4'hC:       o_seg = SEG_C;
            4'hD:       o_seg = SEG_D;
            CODE_BLANK: o_seg = SEG_BLANK;
            CODE_DASH:  o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
// Latches a packed 8-nibble frame and time-multiplexes it onto 8 tubes as
// 4 slots over two segment buses (digit1 -> tubes 7..4, digit2 -> tubes 3..0).
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-low reset
//   data_in     in   32  nibble t = data_in[4t+3:4t] for tube t
//   blink_mask  in   8   per-tube blink enable (used only with SEG_BLINK_EN)
//   frame_tick  out  1   one-cycle pulse when a new frame has been latched
//   digit1      out  8   segments for tubes 7..4
//   digit2      out  8   segments for tubes 3..0
//   tube_sel    out  8   tube enables, active-high
//
// Build option
//   SEG_BLINK_EN  when defined, a free-running phase blanks the segment bus of
//                 any lit tube whose blink_mask bit is set during phase 1.
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int DEAD_CYC = 2,
    parameter int BLINK_HZ = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  blink_mask,
    output logic        frame_tick,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int DIV        = CLK_HZ / SCAN_HZ;
    localparam int CNT_W      = $clog2(DIV);
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);

    logic [CNT_W-1:0] r_cnt;
    slot_e            r_slot;
    logic [31:0]      r_buf;
    logic             r_frame_tick;
    logic [7:0]       r_digit1;
    logic [7:0]       r_digit2;
    logic [7:0]       r_tube_sel;

    logic             w_cnt_wrap;
    logic             w_frame_wrap;
    logic [1:0]       w_idx;
    logic [3:0]       w_code_hi;
    logic [3:0]       w_code_lo;
    logic [7:0]       w_seg_hi;
    logic [7:0]       w_seg_lo;
    logic [7:0]       w_hi_out;
    logic [7:0]       w_lo_out;
    logic [7:0]       w_sel;

    assign w_cnt_wrap   = (r_cnt == CNT_LAST);
    assign w_frame_wrap = w_cnt_wrap && (r_slot == SLOT_LAST);
    assign w_idx        = r_slot;

    // Slot k shows tube k+4 on digit1 and tube k on digit2.
    assign w_code_hi = r_buf[{1'b1, w_idx, 2'b00} +: 4];
    assign w_code_lo = r_buf[{1'b0, w_idx, 2'b00} +: 4];

    // Anti-ghosting: tubes stay dark for the first DEAD_CYC counts of a slot
    // while the segment buses settle on the new digits.
    assign w_sel = (r_cnt < DEAD_LIM) ? 8'h00 : (8'h11 << w_idx);

    seg_decoder u_dec_hi (
        .i_code (w_code_hi),
        .o_seg  (w_seg_hi)
    );

    seg_decoder u_dec_lo (
        .i_code (w_code_lo),
        .o_seg  (w_seg_lo)
    );

`ifdef SEG_BLINK_EN
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_phase;

    // Free-running, independent of the scan counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_blk_cnt == BLK_LAST) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    assign w_hi_out = (r_phase && blink_mask[{1'b1, w_idx}]) ? SEG_BLANK : w_seg_hi;
    assign w_lo_out = (r_phase && blink_mask[{1'b0, w_idx}]) ? SEG_BLANK : w_seg_lo;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{blink_mask, BLINK_HALF[0]};

    assign w_hi_out = w_seg_hi;
    assign w_lo_out = w_seg_lo;
`endif

    // Scan counter, slot FSM, frame buffer and registered outputs.
    // Outputs are computed from the current cnt/slot, so they lag by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_slot       <= SLOT0;
            r_buf        <= FRAME_BLANK;
            r_frame_tick <= 1'b0;
            r_digit1     <= SEG_BLANK;
            r_digit2     <= SEG_BLANK;
            r_tube_sel   <= 8'h00;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_slot <= next_slot(r_slot);
            end
            // data_in is only looked at on the frame boundary, so a frame
            // never mixes old and new nibbles.
            if (w_frame_wrap) begin
                r_buf <= data_in;
            end
            r_frame_tick <= w_frame_wrap;
            r_digit1     <= w_hi_out;
            r_digit2     <= w_lo_out;
            r_tube_sel   <= w_sel;
        end
    end

    assign frame_tick = r_frame_tick;
    assign digit1     = r_digit1;
    assign digit2     = r_digit2;
    assign tube_sel   = r_tube_sel;

endmodule
